// File: rtl/subsample_capture.sv
// Decimated, rising-edge-triggered capture of an ADC sample stream into a
// DEPTH-word buffer with a registered readout port.
module subsample_capture #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rate_sel,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE_ST   = 2'd3
  } state_t;

  state_t              state_reg;
  logic [2:0]          k_next;
  logic [2:0]          k_reg;
  logic [6:0]          cnt_reg;
  logic [6:0]          keep_mask;
  logic                k_change;
  logic                kept;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [DATA_W-1:0]   prev_reg;
  logic                prev_valid_reg;
  logic                trig_hit;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Lowest set bit of the one-hot select wins; an all-zero select means k=0.
  always_comb begin
    k_next = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rate_sel[i]) k_next = 3'(i);
    end
  end

  assign keep_mask = 7'((8'd1 << k_reg) - 8'd1);
  assign k_change  = (k_next != k_reg);
  // A ratio change restarts the count, so the sample in that cycle is not kept.
  assign kept      = adc_valid && !k_change && (cnt_reg == keep_mask);

  assign trig_hit = force_trig ||
                    (prev_valid_reg && (prev_reg < trig_level) && (adc_data >= trig_level));

  // ARM discards any coincident sample, so writes are gated by it too.
  assign wr_en   = kept && !arm &&
                   ((state_reg == WAIT_TRIG && trig_hit) || state_reg == CAPTURE);
  assign wr_addr = (state_reg == WAIT_TRIG) ? '0 : wr_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg   <= 3'd0;
      cnt_reg <= 7'd0;
    end else begin
      k_reg <= k_next;
      if (arm || k_change) begin
        cnt_reg <= 7'd0;
      end else if (adc_valid) begin
        cnt_reg <= kept ? 7'd0 : cnt_reg + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      busy           <= 1'b0;
      triggered      <= 1'b0;
      done           <= 1'b0;
    end else if (arm) begin
      state_reg      <= WAIT_TRIG;
      wr_ptr_reg     <= '0;
      prev_valid_reg <= 1'b0;
      busy           <= 1'b1;
      triggered      <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state_reg)
        WAIT_TRIG: begin
          if (kept) begin
            prev_reg       <= adc_data;
            prev_valid_reg <= 1'b1;
            if (trig_hit) begin
              state_reg  <= CAPTURE;
              wr_ptr_reg <= ADDR_W'(1);
              triggered  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (kept) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            if (wr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
              state_reg <= DONE_ST;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= adc_data;
  end

  // Read-before-write: a same-cycle read of the written address sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule
